// File: rtl/spi_regbank_os.sv
// spi_regbank_os: oversampled SPI slave with a flat register bank, all in sclk.
// Define SPI_RB_PARITY_EN to add a trailing even-parity bit and PAR state.
module spi_regbank_os #(
   parameter int ADDR_W      = 6,
   parameter int DATA_W      = 12,
   parameter int NREGS       = 64,
   parameter bit CPOL        = 1'b0,
   parameter bit CPHA        = 1'b0,
   parameter int SYNC_STAGES = 2
) (
   input  logic                    sclk,
   input  logic                    rstn,
   input  logic                    spi_sck,
   input  logic                    spi_cs_n,
   input  logic                    spi_mosi,
   output logic                    spi_miso,
   output logic                    spi_miso_oe,
   output logic                    wr_stb,
   output logic [ADDR_W-1:0]       wr_addr,
   output logic [DATA_W-1:0]       wr_data,
   output logic                    frame_err,
   output logic [NREGS*DATA_W-1:0] regs_flat
);

   localparam int FRAME_W = 1 + ADDR_W + DATA_W;
   localparam int CNT_W   = $clog2(FRAME_W + 1);
`ifdef SPI_RB_PARITY_EN
   localparam int OUT_W = DATA_W + 1;
`else
   localparam int OUT_W = DATA_W;
`endif
   localparam logic [CNT_W-1:0]  LAST_A  = CNT_W'(ADDR_W);
   localparam logic [CNT_W-1:0]  LAST_D  = CNT_W'(ADDR_W + DATA_W);
   localparam logic [ADDR_W:0]   NREGS_V = (ADDR_W + 1)'(NREGS);

`ifdef SPI_RB_PARITY_EN
   typedef enum logic [2:0] {IDLE, CMD, DATA, PAR, DONE} state_t;
`else
   typedef enum logic [2:0] {IDLE, CMD, DATA, DONE} state_t;
`endif

   state_t state, state_n;

   logic [SYNC_STAGES-1:0] sck_sr, cs_sr, mosi_sr;
   logic [SYNC_STAGES:0]   vld;
   logic sck_p, cs_p, armed;
   logic sck_s, cs_s;
   logic lead_q, trail_q, csf_q, csr_q, mosi_q;
   logic smp, shf;

   logic [CNT_W-1:0]        cnt;
   logic                    rw_q, par_acc, need_shift;
   logic [ADDR_W-1:0]       addr_q, addr_nxt;
   logic [DATA_W-1:0]       data_q, data_nxt, rd_word;
   logic [OUT_W-1:0]        sh_out, ld_word;
   logic                    addr_ok, nxt_ok;
   logic [NREGS*DATA_W-1:0] regs_q;

   assign sck_s = sck_sr[SYNC_STAGES-1];
   assign cs_s  = cs_sr[SYNC_STAGES-1];
   assign smp   = CPHA ? trail_q : lead_q;
   assign shf   = CPHA ? lead_q : trail_q;

   assign addr_nxt = {addr_q[ADDR_W-2:0], mosi_q};
   assign data_nxt = {data_q[DATA_W-2:0], mosi_q};
   assign addr_ok  = {1'b0, addr_q} < NREGS_V;
   assign nxt_ok   = {1'b0, addr_nxt} < NREGS_V;
   assign rd_word  = nxt_ok ? regs_q[int'(addr_nxt)*DATA_W +: DATA_W] : '0;
`ifdef SPI_RB_PARITY_EN
   assign ld_word  = rw_q ? {rd_word, ^rd_word} : '0;
`else
   assign ld_word  = rw_q ? rd_word : '0;
`endif

   assign spi_miso_oe = (state != IDLE);
   assign regs_flat   = regs_q;

   // Pin synchronisers and registered edge events; a frame may only
   // start once cs_n has been seen high after reset (armed).
   always_ff @(posedge sclk) begin
      if (!rstn) begin
         sck_sr  <= '0;
         cs_sr   <= '1;
         mosi_sr <= '0;
         sck_p   <= 1'b0;
         cs_p    <= 1'b1;
         vld     <= '0;
         armed   <= 1'b0;
         lead_q  <= 1'b0;
         trail_q <= 1'b0;
         csf_q   <= 1'b0;
         csr_q   <= 1'b0;
         mosi_q  <= 1'b0;
      end else begin
         sck_sr  <= {sck_sr[SYNC_STAGES-2:0], spi_sck};
         cs_sr   <= {cs_sr[SYNC_STAGES-2:0], spi_cs_n};
         mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], spi_mosi};
         sck_p   <= sck_s;
         cs_p    <= cs_s;
         vld     <= {vld[SYNC_STAGES-1:0], 1'b1};
         if (vld[SYNC_STAGES] && cs_p && cs_s)
            armed <= 1'b1;
         lead_q  <= CPOL ? (sck_p & ~sck_s) : (~sck_p & sck_s);
         trail_q <= CPOL ? (~sck_p & sck_s) : (sck_p & ~sck_s);
         csf_q   <= armed & cs_p & ~cs_s;
         csr_q   <= ~cs_p & cs_s;
         mosi_q  <= mosi_sr[SYNC_STAGES-1];
      end
   end

   // FSM state register.
   always_ff @(posedge sclk) begin
      if (!rstn) state <= IDLE;
      else       state <= state_n;
   end

   // FSM next state; a cs_n rise always wins over a same-cycle SCK edge.
   always_comb begin
      state_n = state;
      unique case (state)
         IDLE: if (csf_q) state_n = CMD;
         CMD: begin
            if (csr_q)
               state_n = IDLE;
            else if (smp && cnt == LAST_A)
               state_n = DATA;
         end
         DATA: begin
            if (csr_q)
               state_n = IDLE;
            else if (smp && cnt == LAST_D)
`ifdef SPI_RB_PARITY_EN
               state_n = PAR;
`else
               state_n = DONE;
`endif
         end
`ifdef SPI_RB_PARITY_EN
         PAR: begin
            if (csr_q)     state_n = IDLE;
            else if (smp)  state_n = DONE;
         end
`endif
         DONE: if (csr_q) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Shift-in, shift-out, register bank update and status pulses.
   always_ff @(posedge sclk) begin
      if (!rstn) begin
         spi_miso   <= 1'b0;
         wr_stb     <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
         frame_err  <= 1'b0;
         regs_q     <= '0;
         cnt        <= '0;
         rw_q       <= 1'b0;
         par_acc    <= 1'b0;
         need_shift <= 1'b0;
         addr_q     <= '0;
         data_q     <= '0;
         sh_out     <= '0;
      end else begin
         wr_stb    <= 1'b0;
         frame_err <= 1'b0;
         unique case (state)
            IDLE: begin
               spi_miso <= 1'b0;
               if (csf_q) begin
                  cnt        <= '0;
                  par_acc    <= 1'b0;
                  need_shift <= 1'b0;
               end
            end
            CMD: begin
               if (csr_q) begin
                  frame_err <= 1'b1;
               end else if (smp) begin
                  cnt     <= cnt + CNT_W'(1);
                  par_acc <= par_acc ^ mosi_q;
                  if (cnt == '0) rw_q   <= mosi_q;
                  else           addr_q <= addr_nxt;
                  if (cnt == LAST_A) begin
                     if (CPHA) begin
                        sh_out     <= ld_word;
                        need_shift <= 1'b1;
                     end else begin
                        spi_miso   <= ld_word[OUT_W-1];
                        sh_out     <= ld_word << 1;
                        need_shift <= 1'b0;
                     end
                  end
               end
            end
            DATA: begin
               if (csr_q) begin
                  frame_err <= 1'b1;
                  spi_miso  <= 1'b0;
               end else begin
                  if (shf && need_shift) begin
                     spi_miso   <= sh_out[OUT_W-1];
                     sh_out     <= sh_out << 1;
                     need_shift <= 1'b0;
                  end
                  if (smp) begin
                     cnt        <= cnt + CNT_W'(1);
                     par_acc    <= par_acc ^ mosi_q;
                     data_q     <= data_nxt;
                     need_shift <= 1'b1;
`ifndef SPI_RB_PARITY_EN
                     if (cnt == LAST_D) begin
                        spi_miso   <= 1'b0;
                        need_shift <= 1'b0;
                        if (!rw_q && addr_ok) begin
                           regs_q[int'(addr_q)*DATA_W +: DATA_W] <= data_nxt;
                           wr_stb  <= 1'b1;
                           wr_addr <= addr_q;
                           wr_data <= data_nxt;
                        end
                     end
`endif
                  end
               end
            end
`ifdef SPI_RB_PARITY_EN
            PAR: begin
               if (csr_q) begin
                  frame_err <= 1'b1;
                  spi_miso  <= 1'b0;
               end else begin
                  if (shf && need_shift) begin
                     spi_miso   <= sh_out[OUT_W-1];
                     need_shift <= 1'b0;
                  end
                  if (smp) begin
                     spi_miso   <= 1'b0;
                     need_shift <= 1'b0;
                     if (par_acc ^ mosi_q) begin
                        frame_err <= 1'b1;
                     end else if (!rw_q && addr_ok) begin
                        regs_q[int'(addr_q)*DATA_W +: DATA_W] <= data_q;
                        wr_stb  <= 1'b1;
                        wr_addr <= addr_q;
                        wr_data <= data_q;
                     end
                  end
               end
            end
`endif
            DONE: spi_miso <= 1'b0;
            default: spi_miso <= 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_regbank_os.sv
// tb_spi_regbank_os: directed bench, mode-0 and mode-3 instances, NREGS=40.
// Parity checks are built when SPI_RB_PARITY_EN is defined.
module tb_spi_regbank_os;

   localparam int AW = 6;
   localparam int DW = 12;
   localparam int NR = 40;
`ifdef SPI_RB_PARITY_EN
   localparam int FL = 20;
`else
   localparam int FL = 19;
`endif

   logic sclk = 1'b0;
   logic rstn = 1'b0;
   logic [1:0] sck  = 2'b10;
   logic [1:0] csn  = 2'b11;
   logic [1:0] mosi = 2'b00;
   logic [1:0] miso, oe, wstb, ferr;
   logic [AW-1:0] wa0, wa1;
   logic [DW-1:0] wd0, wd1;
   logic [NR*DW-1:0] rf0, rf1;

   logic [DW-1:0] m0 [NR];
   logic [DW-1:0] m1 [NR];

   int checks = 0;
   int errors = 0;
   int wc0 = 0, wc1 = 0, fc0 = 0, fc1 = 0;

   always #5 sclk = ~sclk;

   spi_regbank_os #(
      .ADDR_W(AW), .DATA_W(DW), .NREGS(NR),
      .CPOL(1'b0), .CPHA(1'b0), .SYNC_STAGES(2)
   ) u0 (
      .sclk(sclk), .rstn(rstn),
      .spi_sck(sck[0]), .spi_cs_n(csn[0]), .spi_mosi(mosi[0]),
      .spi_miso(miso[0]), .spi_miso_oe(oe[0]),
      .wr_stb(wstb[0]), .wr_addr(wa0), .wr_data(wd0),
      .frame_err(ferr[0]), .regs_flat(rf0)
   );

   spi_regbank_os #(
      .ADDR_W(AW), .DATA_W(DW), .NREGS(NR),
      .CPOL(1'b1), .CPHA(1'b1), .SYNC_STAGES(2)
   ) u3 (
      .sclk(sclk), .rstn(rstn),
      .spi_sck(sck[1]), .spi_cs_n(csn[1]), .spi_mosi(mosi[1]),
      .spi_miso(miso[1]), .spi_miso_oe(oe[1]),
      .wr_stb(wstb[1]), .wr_addr(wa1), .wr_data(wd1),
      .frame_err(ferr[1]), .regs_flat(rf1)
   );

   // Count high cycles of each pulse output (a clean pulse adds exactly 1).
   always @(negedge sclk) begin
      if (wstb[0]) wc0 = wc0 + 1;
      if (wstb[1]) wc1 = wc1 + 1;
      if (ferr[0]) fc0 = fc0 + 1;
      if (ferr[1]) fc1 = fc1 + 1;
   end

   function automatic logic [NR*DW-1:0] flat(input int dev);
      logic [NR*DW-1:0] f;
      for (int i = 0; i < NR; i++)
         f[i*DW +: DW] = (dev == 1) ? m1[i] : m0[i];
      return f;
   endfunction

   task automatic clr_model();
      for (int i = 0; i < NR; i++) begin
         m0[i] = '0;
         m1[i] = '0;
      end
   endtask

   task automatic half();
      repeat (8) @(negedge sclk);
   endtask

   // SPI master: mode 0 for dev 0, mode 3 for dev 1.
   task automatic xfer(input int dev, input logic rw, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input int nb, input logic badp,
                       input logic fall, input logic keep,
                       output logic [DW-1:0] rd, output logic rp,
                       output logic ok);
      logic [18:0] fr;
      logic par, b;
      fr  = {rw, a, d};
      par = (^fr) ^ badp;
      rd  = '0;
      rp  = 1'b0;
      ok  = 1'b1;
      if (fall) begin
         csn[dev] = 1'b0;
         half();
      end
      for (int i = 0; i < nb; i++) begin
         b = (i < 19) ? fr[18-i] : par;
         if (dev == 0) begin
            mosi[dev] = b;
            half();
            sck[dev] = 1'b1;
         end else begin
            sck[dev] = 1'b0;
            mosi[dev] = b;
            half();
            sck[dev] = 1'b1;
         end
         if (i >= 7 && i < 19) rd[18-i] = miso[dev];
         if (i == 19) rp = miso[dev];
         if (oe[dev] !== 1'b1) ok = 1'b0;
         half();
         if (dev == 0) sck[dev] = 1'b0;
      end
      half();
      if (!keep) begin
         csn[dev] = 1'b1;
         repeat (4) half();
      end
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      repeat (4) @(negedge sclk);
      checks++;
      if ({miso, oe} !== 4'b0) begin
         errors++;
         $display("FAIL reset_in miso/oe got %b expected 0000", {miso, oe});
      end
      rstn = 1'b1;
      repeat (20) @(negedge sclk);
      checks++;
      if ({miso, oe, wstb, ferr} !== 8'h00) begin
         errors++;
         $display("FAIL reset_ctl got %h expected 00", {miso, oe, wstb, ferr});
      end
      checks++;
      if ({wa0, wd0, wa1, wd1} !== 36'h0) begin
         errors++;
         $display("FAIL reset_wr got %h expected 0", {wa0, wd0, wa1, wd1});
      end
      checks++;
      if (rf0 !== '0 || rf1 !== '0) begin
         errors++;
         $display("FAIL reset_regs got %h / %h expected 0", rf0, rf1);
      end
   endtask

   task automatic test_write_mode0();
      logic [DW-1:0] rd;
      logic rp, ok;
      int w, f;
      w = wc0;
      f = fc0;
      xfer(0, 1'b0, 6'd5, 12'hABC, FL, 1'b0, 1'b1, 1'b0, rd, rp, ok);
      m0[5] = 12'hABC;
      checks++;
      if (wc0 - w !== 1) begin
         errors++;
         $display("FAIL wr5_stb got %0d pulses expected 1", wc0 - w);
      end
      checks++;
      if (wa0 !== 6'd5 || wd0 !== 12'hABC) begin
         errors++;
         $display("FAIL wr5_bus got %0d/%h expected 5/abc", wa0, wd0);
      end
      checks++;
      if (rf0[71:60] !== 12'hABC) begin
         errors++;
         $display("FAIL wr5_reg got %h expected abc", rf0[71:60]);
      end
      xfer(0, 1'b0, 6'd39, 12'hFFF, FL, 1'b0, 1'b1, 1'b0, rd, rp, ok);
      xfer(0, 1'b0, 6'd0, 12'h123, FL, 1'b0, 1'b1, 1'b0, rd, rp, ok);
      m0[39] = 12'hFFF;
      m0[0]  = 12'h123;
      checks++;
      if (wc0 - w !== 3 || fc0 !== f) begin
         errors++;
         $display("FAIL wr_cnt got %0d wr %0d err expected 3 0", wc0 - w, fc0 - f);
      end
      checks++;
      if (rf0 !== flat(0)) begin
         errors++;
         $display("FAIL wr_regs got %h expected %h", rf0, flat(0));
      end
   endtask

   task automatic test_read_mode0();
      logic [DW-1:0] rd;
      logic rp, ok;
      int w;
      w = wc0;
      xfer(0, 1'b1, 6'd5, 12'h000, FL, 1'b0, 1'b1, 1'b0, rd, rp, ok);
      checks++;
      if (rd !== 12'b1010_1011_1100) begin
         errors++;
         $display("FAIL rd5 got %h expected abc", rd);
      end
      checks++;
      if (ok !== 1'b1 || oe[0] !== 1'b0) begin
         errors++;
         $display("FAIL rd5_oe frame %b idle %b expected 1 0", ok, oe[0]);
      end
`ifdef SPI_RB_PARITY_EN
      checks++;
      if (rp !== 1'b1) begin
         errors++;
         $display("FAIL rd5_par got %b expected 1", rp);
      end
`endif
      xfer(0, 1'b1, 6'd39, 12'h000, FL, 1'b0, 1'b1, 1'b0, rd, rp, ok);
      checks++;
      if (rd !== 12'hFFF || wc0 !== w) begin
         errors++;
         $display("FAIL rd39 got %h wr %0d expected fff 0", rd, wc0 - w);
      end
   endtask

   task automatic test_out_of_range();
      logic [DW-1:0] rd;
      logic rp, ok;
      int w;
      w = wc0;
      xfer(0, 1'b0, 6'd63, 12'h777, FL, 1'b0, 1'b1, 1'b0, rd, rp, ok);
      xfer(0, 1'b0, 6'd40, 12'h555, FL, 1'b0, 1'b1, 1'b0, rd, rp, ok);
      checks++;
      if (wc0 !== w) begin
         errors++;
         $display("FAIL oor_stb got %0d pulses expected 0", wc0 - w);
      end
      checks++;
      if (rf0 !== flat(0)) begin
         errors++;
         $display("FAIL oor_regs got %h expected %h", rf0, flat(0));
      end
      xfer(0, 1'b1, 6'd63, 12'h000, FL, 1'b0, 1'b1, 1'b0, rd, rp, ok);
      checks++;
      if (rd !== 12'h000) begin
         errors++;
         $display("FAIL oor_rd got %h expected 000", rd);
      end
   endtask

   task automatic test_abort();
      logic [DW-1:0] rd;
      logic rp, ok;
      int w, f;
      w = wc0;
      f = fc0;
      xfer(0, 1'b0, 6'd7, 12'h0F0, 10, 1'b0, 1'b1, 1'b0, rd, rp, ok);
      checks++;
      if (fc0 - f !== 1 || wc0 !== w) begin
         errors++;
         $display("FAIL abort got err %0d wr %0d expected 1 0", fc0 - f, wc0 - w);
      end
      checks++;
      if (rf0 !== flat(0)) begin
         errors++;
         $display("FAIL abort_regs got %h expected %h", rf0, flat(0));
      end
      xfer(0, 1'b0, 6'd7, 12'h0F0, FL, 1'b0, 1'b1, 1'b0, rd, rp, ok);
      m0[7] = 12'h0F0;
      checks++;
      if (wc0 - w !== 1 || wd0 !== 12'h0F0 || rf0 !== flat(0)) begin
         errors++;
         $display("FAIL after_abort got wr %0d data %h expected 1 0f0", wc0 - w, wd0);
      end
   endtask

   task automatic test_mode3();
      logic [DW-1:0] rd;
      logic rp, ok;
      int w;
      w = wc0;
      xfer(1, 1'b0, 6'd0, 12'h5A5, FL, 1'b0, 1'b1, 1'b0, rd, rp, ok);
      m1[0] = 12'h5A5;
      checks++;
      if (wc1 !== 1 || wa1 !== 6'd0 || wd1 !== 12'h5A5) begin
         errors++;
         $display("FAIL m3_wr got %0d %0d %h expected 1 0 5a5", wc1, wa1, wd1);
      end
      checks++;
      if (rf1 !== flat(1) || wc0 !== w) begin
         errors++;
         $display("FAIL m3_regs got %h expected %h", rf1, flat(1));
      end
      xfer(1, 1'b1, 6'd0, 12'h000, FL, 1'b0, 1'b1, 1'b0, rd, rp, ok);
      checks++;
      if (rd !== 12'h5A5 || ok !== 1'b1) begin
         errors++;
         $display("FAIL m3_rd got %h oe %b expected 5a5 1", rd, ok);
      end
   endtask

   task automatic test_reset_mid();
      logic [DW-1:0] rd;
      logic rp, ok;
      int w, f;
      xfer(1, 1'b1, 6'd0, 12'h000, 10, 1'b0, 1'b1, 1'b1, rd, rp, ok);
      f = fc1;
      rstn = 1'b0;
      repeat (3) @(negedge sclk);
      clr_model();
      checks++;
      if ({miso, oe, wstb, ferr} !== 8'h00 ||
          {wa0, wd0, wa1, wd1} !== 36'h0) begin
         errors++;
         $display("FAIL mid_rst_out got %h %h expected 0",
                  {miso, oe, wstb, ferr}, {wa0, wd0, wa1, wd1});
      end
      checks++;
      if (rf0 !== '0 || rf1 !== '0) begin
         errors++;
         $display("FAIL mid_rst_regs got %h / %h expected 0", rf0, rf1);
      end
      rstn = 1'b1;
      repeat (20) @(negedge sclk);
      w = wc1;
      xfer(1, 1'b0, 6'd3, 12'h111, FL, 1'b0, 1'b0, 1'b0, rd, rp, ok);
      checks++;
      if (wc1 !== w || fc1 !== f || rf1 !== '0) begin
         errors++;
         $display("FAIL no_fall got wr %0d err %0d expected 0 0", wc1 - w, fc1 - f);
      end
      xfer(1, 1'b1, 6'd0, 12'h000, FL, 1'b0, 1'b1, 1'b0, rd, rp, ok);
      checks++;
      if (rd !== 12'h000) begin
         errors++;
         $display("FAIL post_rst_rd got %h expected 000", rd);
      end
      xfer(1, 1'b0, 6'd2, 12'h321, FL, 1'b0, 1'b1, 1'b0, rd, rp, ok);
      m1[2] = 12'h321;
      checks++;
      if (wc1 - w !== 1 || rf1 !== flat(1) || fc1 !== f) begin
         errors++;
         $display("FAIL post_rst_wr got wr %0d err %0d expected 1 0", wc1 - w, fc1 - f);
      end
   endtask

`ifdef SPI_RB_PARITY_EN
   task automatic test_parity();
      logic [DW-1:0] rd;
      logic rp, ok;
      int w, f;
      w = wc0;
      f = fc0;
      xfer(0, 1'b0, 6'd9, 12'h246, FL, 1'b1, 1'b1, 1'b0, rd, rp, ok);
      checks++;
      if (fc0 - f !== 1 || wc0 !== w || rf0 !== flat(0)) begin
         errors++;
         $display("FAIL bad_par got err %0d wr %0d expected 1 0", fc0 - f, wc0 - w);
      end
      xfer(0, 1'b0, 6'd9, 12'h246, FL, 1'b0, 1'b1, 1'b0, rd, rp, ok);
      m0[9] = 12'h246;
      checks++;
      if (fc0 - f !== 1 || wc0 - w !== 1 || rf0 !== flat(0)) begin
         errors++;
         $display("FAIL good_par got err %0d wr %0d expected 1 1", fc0 - f, wc0 - w);
      end
   endtask
`endif

   initial begin
      clr_model();
      test_reset();
      test_write_mode0();
      test_read_mode0();
      test_out_of_range();
      test_abort();
      test_mode3();
      test_reset_mid();
`ifdef SPI_RB_PARITY_EN
      test_parity();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/spi_regbank_os.md
# spi_regbank_os

Oversampled SPI slave with a parametrised register bank, the next generation of the team's SPI register interface. The whole block runs in the system clock domain `sclk`: SPI pins are synchronised and edge-detected rather than used as clocks. Supported: all four SPI modes, configurable address/data widths, and same-frame read response. It sits between the external SPI master pins and the internal control registers, exposing every register as a flat output bus plus a write strobe.

## Interface
- `ADDR_W`, 6, address field width
- `DATA_W`, 12, data field and register width
- `NREGS`, 64, implemented registers, 1..2**ADDR_W
- `CPOL`, 0, SPI clock idle level
- `CPHA`, 0, 0 = sample on leading edge, 1 = sample on trailing edge
- `SYNC_STAGES`, 2, synchroniser depth for `spi_sck`/`spi_cs_n`/`spi_mosi`, ≥2
- `sclk`  in  1  system clock; all logic on posedge
- `rstn`  in  1  synchronous, active-low reset
- `spi_sck`  in  1  SPI clock, asynchronous
- `spi_cs_n`  in  1  chip select, active low, asynchronous
- `spi_mosi`  in  1  master-out data, asynchronous
- `spi_miso`  out  1  slave-out data
- `spi_miso_oe`  out  1  MISO output enable
- `wr_stb`  out  1  one-cycle pulse on committed write
- `wr_addr`  out  ADDR_W  address of the last committed write
- `wr_data`  out  DATA_W  data of the last committed write
- `frame_err`  out  1  one-cycle pulse on aborted or rejected frame
- `regs_flat`  out  NREGS*DATA_W  register i at bits [i*DATA_W +: DATA_W]

## Operation
- Frame, MSB-first: RWb (1 = read), ADDR_W address bits, DATA_W data bits. FRAME_W = 1+ADDR_W+DATA_W.
- Sample edge: leading edge if CPHA=0, trailing edge if CPHA=1. Shift edge is the opposite edge. Leading edge is rising if CPOL=0, falling if CPOL=1.
- FSM states:
  - IDLE: entered on synced cs_n high.
  - CMD: entered on synced cs_n fall; samples RWb and address.
  - DATA: entered after the last address sample; samples DATA_W bits.
  - DONE: entered after the final data sample; further edges are ignored and MISO is 0 until cs_n rises.
- Write: at the final data sample, if addr < NREGS, `REGS[addr]` is updated and `wr_stb`/`wr_addr`/`wr_data` are driven. If addr ≥ NREGS, there is no update and no strobe.
- Read: at the last address sample, the shift-out register loads `REGS[addr]`, or 0 if addr ≥ NREGS. Its MSB is driven on the next shift edge. For CPHA=0, it is driven on the CMD→DATA transition cycle.
  - Data bits on MOSI are ignored during reads.
  - MISO is 0 during CMD and DONE.
- `spi_miso_oe` is high in every state except IDLE.
- Abort: if cs_n rises in CMD or DATA, the FSM returns to IDLE and `frame_err` pulses. No write occurs.
- cs_n rising in DONE is a normal end of frame with no error.
- Bit counter width: clog2(FRAME_W+1). It resets on every cs_n fall.

## Timing
- Requirement: f_sclk ≥ 8·f_spi_sck. Every SPI high/low phase is ≥4 sclk cycles.
- Edge detection happens SYNC_STAGES+1 cycles after a pin transition.
- `wr_stb` and the `regs_flat` update occur 1 cycle after the detected final sample edge, i.e. SYNC_STAGES+2 sclk after the pin edge.
- `spi_miso` changes 1 cycle after the detected shift edge.
- `frame_err` asserts 1 cycle after the synced cs_n rise and lasts exactly 1 cycle.
- A cs_n rise and an SCK edge detected in the same cycle: the cs_n rise wins. That edge is discarded; if the frame is incomplete, it is treated as an abort.
- Reset values:
  - FSM: IDLE
  - `spi_miso`: 0
  - `spi_miso_oe`: 0
  - `wr_stb`: 0
  - `wr_addr`: 0
  - `wr_data`: 0
  - `frame_err`: 0
  - All registers (`regs_flat`): 0
  - Synchronisers: cs_n stage 1, others 0
- Reset mid-frame: the frame is discarded with no write and no `frame_err`. The block waits for a fresh cs_n fall. An already-low cs_n does not start a frame.

## Configuration
- `SPI_RB_PARITY_EN` defined:
  - Frame gains one trailing even-parity bit covering all FRAME_W bits, and the FSM adds state PAR after DATA.
  - Write commits at the parity sample, and only if parity matches. On mismatch: no write, `frame_err` pulses.
  - Reads: the slave drives even parity of the read data on MISO during PAR. Master parity is still checked; a mismatch pulses `frame_err`.
- `SPI_RB_PARITY_EN` undefined: frame is FRAME_W bits and there is no PAR state.

## Test plan
- Mode 0 write 0xABC to addr 5 -> `wr_stb` pulse with `wr_addr`=5, `wr_data`=0xABC; `regs_flat[71:60]`=0xABC.
- Mode 0 read addr 5 after the write -> MISO returns 1010_1011_1100 in the same frame; `spi_miso_oe` high for the whole frame.
- Write addr 63 with NREGS=40 -> no `wr_stb`, `regs_flat` unchanged. Read addr 63 -> MISO all zeros.
- cs_n raised after 10 bits of a write -> `frame_err` single pulse, no register change, next full frame works.
- CPOL=1/CPHA=1 build, write 0x5A5 to addr 0 then read -> 0x5A5 returned; assert `rstn` mid-read -> all outputs 0, no `frame_err`.
- With `SPI_RB_PARITY_EN`, write with wrong parity bit -> `frame_err` pulse, no write. Correct parity -> write commits.
